address_unit: RTL and testbench

ADDRESS_UNIT -- requirements
Module: address_unit

---
 rtl/address_unit_pkg.sv | 36 +++
 rtl/address_unit_if.sv | 30 +++
 rtl/address_unit_program_counter.sv | 35 +++
 rtl/address_unit.sv | 113 +++++++++++
 tb/tb_address_unit.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/address_unit_pkg.sv
// Shared definitions for the address unit: address-source encodings,
// reset-vector locations, the NOP opcode, bus widths and state encodings.
// Configuration macro: ADDRESS_UNIT_RESET_VECTOR_EN selects whether the
// startup vector-fetch states exist.
package address_unit_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;

  // Where the external address bus is sourced from this cycle
  typedef enum logic [1:0] {
    ADDR_SEL_PC   = 2'd0,
    ADDR_SEL_MEM  = 2'd1,
    ADDR_SEL_ZP   = 2'd2,
    ADDR_SEL_HOLD = 2'd3
  } addrSel_t;

  localparam logic [ADDR_W-1:0] RESET_VECTOR_LO = 16'hFFFC;
  localparam logic [ADDR_W-1:0] RESET_VECTOR_HI = 16'hFFFD;
  localparam logic [DATA_W-1:0] OPCODE_NOP      = 8'hEA;

`ifdef ADDRESS_UNIT_RESET_VECTOR_EN
  typedef enum logic [1:0] {
    ST_RESET_LO = 2'd0,
    ST_RESET_HI = 2'd1,
    ST_RUN      = 2'd2
  } state_t;
  localparam state_t START_STATE = ST_RESET_LO;
`else
  typedef enum logic [1:0] {
    ST_RUN = 2'd2
  } state_t;
  localparam state_t START_STATE = ST_RUN;
`endif

endpackage

// File: rtl/address_unit_if.sv
// Decode/bus-side signal bundle of the address unit. The master modport is
// the instruction-decode / bus side; the slave modport is the address unit.
interface address_unit_if;
  import address_unit_pkg::*;

  logic                clk_enable;
  logic                pc_enable;
  logic [1:0]          address_select;
  logic [ADDR_W-1:0]   memory_address;
  logic [DATA_W-1:0]   alu_result;
  logic                rw;
  logic [DATA_W-1:0]   data_in;
  logic [ADDR_W-1:0]   address;
  logic                rw_out;
  logic [DATA_W-1:0]   instruction;
  logic [ADDR_W-1:0]   pc;
  logic                ready;

  modport master (
    output clk_enable, pc_enable, address_select, memory_address,
           alu_result, rw, data_in,
    input  address, rw_out, instruction, pc, ready
  );

  modport slave (
    input  clk_enable, pc_enable, address_select, memory_address,
           alu_result, rw, data_in,
    output address, rw_out, instruction, pc, ready
  );
endinterface

// File: rtl/address_unit_program_counter.sv
// Program counter: byte-wise loads for the startup vector fetch, plus a
// free-running 16-bit increment that wraps FFFF -> 0000.
module program_counter
  import address_unit_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_enable,
  input  logic              i_loadLo,
  input  logic              i_loadHi,
  input  logic              i_increment,
  input  logic [DATA_W-1:0] i_data,
  output logic [ADDR_W-1:0] o_pc
);

  logic [ADDR_W-1:0] r_pc;

  // Loads take priority over increment; nothing moves on a disabled cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= '0;
    end else if (i_enable) begin
      if (i_loadLo) begin
        r_pc[7:0] <= i_data;
      end else if (i_loadHi) begin
        r_pc[15:8] <= i_data;
      end else if (i_increment) begin
        r_pc <= r_pc + 16'd1;
      end
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/address_unit.sv
// Address unit top: address-bus mux, startup state machine, instruction
// latch and read/write strobe; the PC lives in program_counter.
// Configuration macro: ADDRESS_UNIT_RESET_VECTOR_EN. When defined the unit
// fetches the start PC from FFFC/FFFD after reset; otherwise it starts in
// RUN with PC = 0000.
module address_unit
  import address_unit_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  address_unit_if.slave bus
);

  state_t            r_state;
  state_t            w_stateNext;
  logic [ADDR_W-1:0] r_addrQ;
  logic [DATA_W-1:0] r_instruction;
  logic [ADDR_W-1:0] w_address;
  logic [ADDR_W-1:0] w_pc;
  logic              w_loadLo;
  logic              w_loadHi;
  logic              w_increment;
  logic              w_capture;
  logic              w_rwOut;
  logic              w_ready;

  program_counter u_pc (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_enable    (bus.clk_enable),
    .i_loadLo    (w_loadLo),
    .i_loadHi    (w_loadHi),
    .i_increment (w_increment),
    .i_data      (bus.data_in),
    .o_pc        (w_pc)
  );

  // State register; reset always returns to the startup state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= START_STATE;
    end else if (bus.clk_enable) begin
      r_state <= w_stateNext;
    end
  end

  // Next state plus every per-state control; decode inputs only matter in RUN
  always_comb begin
    w_stateNext = r_state;
    w_address   = r_addrQ;
    w_loadLo    = 1'b0;
    w_loadHi    = 1'b0;
    w_increment = 1'b0;
    w_capture   = 1'b0;
    w_rwOut     = 1'b1;
    w_ready     = 1'b0;
    case (r_state)
`ifdef ADDRESS_UNIT_RESET_VECTOR_EN
      ST_RESET_LO: begin
        w_address   = RESET_VECTOR_LO;
        w_loadLo    = 1'b1;
        w_stateNext = ST_RESET_HI;
      end
      ST_RESET_HI: begin
        w_address   = RESET_VECTOR_HI;
        w_loadHi    = 1'b1;
        w_stateNext = ST_RUN;
      end
`endif
      ST_RUN: begin
        w_increment = bus.pc_enable;
        w_capture   = bus.rw;
        w_rwOut     = bus.rw;
        w_ready     = 1'b1;
        case (addrSel_t'(bus.address_select))
          ADDR_SEL_PC:   w_address = w_pc;
          ADDR_SEL_MEM:  w_address = bus.memory_address;
          ADDR_SEL_ZP:   w_address = {8'h00, bus.alu_result};
          ADDR_SEL_HOLD: w_address = r_addrQ;
          default:       w_address = r_addrQ;
        endcase
      end
      default: begin
        w_stateNext = START_STATE;
      end
    endcase
  end

  // Remember whatever address was driven so HOLD can repeat it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addrQ <= '0;
    end else if (bus.clk_enable) begin
      r_addrQ <= w_address;
    end
  end

  // Latch the bus byte for decode on enabled read cycles in RUN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instruction <= OPCODE_NOP;
    end else if (bus.clk_enable && w_capture) begin
      r_instruction <= bus.data_in;
    end
  end

  assign bus.address     = w_address;
  assign bus.rw_out      = w_rwOut;
  assign bus.instruction = r_instruction;
  assign bus.pc          = w_pc;
  assign bus.ready       = w_ready;

endmodule

// File: tb/tb_address_unit.sv
// Scoreboard testbench for address_unit. Stimulus pushes expected output
// values into a queue before each clock edge; a monitor on the falling edge
// pops and compares them. Both builds of ADDRESS_UNIT_RESET_VECTOR_EN are
// covered by the matching `ifdef branch.
module tb_address_unit;
  import address_unit_pkg::*;

  typedef enum int {F_ADDR, F_PC, F_INSTR, F_RWOUT, F_READY} field_t;

  typedef struct {
    string       name;
    field_t      field;
    logic [15:0] value;
  } expect_t;

  logic clk;
  logic rst_n;
  address_unit_if bus ();

  expect_t sbQ[$];
  int      nCompared;
  int      nMismatched;

  address_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Look up one DUT output as a 16-bit value
  function automatic logic [15:0] getField(field_t f);
    case (f)
      F_ADDR:  return bus.address;
      F_PC:    return bus.pc;
      F_INSTR: return {8'h00, bus.instruction};
      F_RWOUT: return {15'h0, bus.rw_out};
      F_READY: return {15'h0, bus.ready};
      default: return 16'hxxxx;
    endcase
  endfunction

  // Monitor: compare every queued expectation midway between rising edges
  initial begin
    expect_t item;
    logic [15:0] act;
    forever begin
      @(negedge clk);
      while (sbQ.size() > 0) begin
        item = sbQ.pop_front();
        act  = getField(item.field);
        nCompared++;
        if (act !== item.value) begin
          nMismatched++;
          $display("[TB] FAIL %s: got %h expected %h", item.name, act, item.value);
        end
      end
    end
  end

  // Drive all decode-side inputs for the coming cycle
  task automatic applyStimulus(input logic ce, input logic pe, input logic [1:0] sel,
                               input logic [15:0] mem, input logic [7:0] alu,
                               input logic rw, input logic [7:0] din);
    bus.clk_enable     = ce;
    bus.pc_enable      = pe;
    bus.address_select = sel;
    bus.memory_address = mem;
    bus.alu_result     = alu;
    bus.rw             = rw;
    bus.data_in        = din;
  endtask

  // Queue one expected output value for the next monitor sample
  task automatic checkOutput(input string name, input field_t f, input logic [15:0] v);
    expect_t e;
    e.name  = name;
    e.field = f;
    e.value = v;
    sbQ.push_back(e);
  endtask

  // Let the monitor sample, then move past the next rising edge
  task automatic stepCycle();
    @(posedge clk);
    #2;
  endtask

  // RUN-state behaviour shared by both builds; p is the PC on entry and
  // prevInstr the instruction latched before the first step
  task automatic runCommon(input logic [15:0] p, input logic [7:0] prevInstr);
    applyStimulus(1'b1, 1'b0, 2'd2, 16'h0000, 8'h85, 1'b0, 8'hAA);
    checkOutput("zp_addr", F_ADDR, 16'h0085);
    checkOutput("write_rwout", F_RWOUT, 16'h0000);
    checkOutput("instr_before_write", F_INSTR, {8'h00, prevInstr});
    stepCycle();
    applyStimulus(1'b1, 1'b0, 2'd3, 16'h0000, 8'h00, 1'b1, 8'hA5);
    checkOutput("hold_addr", F_ADDR, 16'h0085);
    checkOutput("instr_after_write", F_INSTR, {8'h00, prevInstr});
    checkOutput("read_rwout", F_RWOUT, 16'h0001);
    stepCycle();
    applyStimulus(1'b1, 1'b1, 2'd1, 16'hBEEF, 8'h00, 1'b1, 8'hA5);
    checkOutput("mem_addr", F_ADDR, 16'hBEEF);
    checkOutput("instr_read_a5", F_INSTR, 16'h00A5);
    checkOutput("pc_before_inc", F_PC, p);
    stepCycle();
    applyStimulus(1'b0, 1'b1, 2'd0, 16'h0000, 8'h00, 1'b1, 8'h11);
    checkOutput("pc_inc_with_mem", F_PC, p + 16'd1);
    checkOutput("pc_addr", F_ADDR, p + 16'd1);
    stepCycle();
    applyStimulus(1'b1, 1'b0, 2'd3, 16'h0000, 8'h00, 1'b1, 8'h11);
    checkOutput("pc_held_ce0", F_PC, p + 16'd1);
    checkOutput("addrq_held_ce0", F_ADDR, 16'hBEEF);
    checkOutput("instr_held_ce0", F_INSTR, 16'h00A5);
    stepCycle();
    applyStimulus(1'b1, 1'b0, 2'd0, 16'h0000, 8'h00, 1'b1, 8'h22);
    checkOutput("instr_read_11", F_INSTR, 16'h0011);
    checkOutput("pc_addr_again", F_ADDR, p + 16'd1);
    stepCycle();
  endtask

  // Directed sequence
  initial begin
    nCompared   = 0;
    nMismatched = 0;
    rst_n       = 1'b0;
    applyStimulus(1'b0, 1'b0, 2'd0, 16'h0000, 8'h00, 1'b1, 8'h00);
    #2;
`ifdef ADDRESS_UNIT_RESET_VECTOR_EN
    checkOutput("rst_ready", F_READY, 16'h0000);
    checkOutput("rst_pc", F_PC, 16'h0000);
    checkOutput("rst_instr", F_INSTR, 16'h00EA);
    checkOutput("rst_addr", F_ADDR, 16'hFFFC);
    checkOutput("rst_rwout", F_RWOUT, 16'h0001);
    stepCycle();
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b0, 2'd0, 16'h0000, 8'h00, 1'b1, 8'h34);
    checkOutput("vec_lo_addr", F_ADDR, 16'hFFFC);
    checkOutput("vec_lo_ready", F_READY, 16'h0000);
    stepCycle();
    applyStimulus(1'b1, 1'b0, 2'd0, 16'h0000, 8'h00, 1'b1, 8'h12);
    checkOutput("vec_hi_addr", F_ADDR, 16'hFFFD);
    checkOutput("vec_hi_pc", F_PC, 16'h0034);
    stepCycle();
    applyStimulus(1'b1, 1'b0, 2'd0, 16'h0000, 8'h00, 1'b1, 8'h55);
    checkOutput("vec_pc", F_PC, 16'h1234);
    checkOutput("vec_ready", F_READY, 16'h0001);
    checkOutput("vec_instr_nop", F_INSTR, 16'h00EA);
    checkOutput("run_addr_pc", F_ADDR, 16'h1234);
    stepCycle();
    runCommon(16'h1234, 8'h55);

    // Reset during RESET_HI, with decode inputs that must be ignored
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b1, 2'd2, 16'h0000, 8'h77, 1'b0, 8'hFF);
    checkOutput("fetch_ignore_sel", F_ADDR, 16'hFFFC);
    checkOutput("fetch_ignore_rw", F_RWOUT, 16'h0001);
    stepCycle();
    applyStimulus(1'b1, 1'b0, 2'd0, 16'h0000, 8'h00, 1'b1, 8'h99);
    rst_n = 1'b0;
    checkOutput("midrst_ready", F_READY, 16'h0000);
    checkOutput("midrst_pc", F_PC, 16'h0000);
    checkOutput("midrst_addr", F_ADDR, 16'hFFFC);
    stepCycle();
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b0, 2'd0, 16'h0000, 8'h00, 1'b1, 8'hFF);
    checkOutput("refetch_lo_addr", F_ADDR, 16'hFFFC);
    stepCycle();
    applyStimulus(1'b1, 1'b0, 2'd0, 16'h0000, 8'h00, 1'b1, 8'hFF);
    checkOutput("refetch_hi_addr", F_ADDR, 16'hFFFD);
    checkOutput("refetch_hi_pc", F_PC, 16'h00FF);
    stepCycle();
    applyStimulus(1'b0, 1'b1, 2'd0, 16'h0000, 8'h00, 1'b1, 8'h00);
    checkOutput("wrap_pc_ffff", F_PC, 16'hFFFF);
    checkOutput("wrap_ready", F_READY, 16'h0001);
    stepCycle();
    applyStimulus(1'b1, 1'b1, 2'd0, 16'h0000, 8'h00, 1'b1, 8'h00);
    checkOutput("wrap_hold_ce0", F_PC, 16'hFFFF);
    stepCycle();
    applyStimulus(1'b1, 1'b0, 2'd0, 16'h0000, 8'h00, 1'b1, 8'h00);
    checkOutput("wrap_pc_0000", F_PC, 16'h0000);
    checkOutput("wrap_addr_0000", F_ADDR, 16'h0000);
    stepCycle();
`else
    checkOutput("rst_ready", F_READY, 16'h0001);
    checkOutput("rst_pc", F_PC, 16'h0000);
    checkOutput("rst_instr", F_INSTR, 16'h00EA);
    checkOutput("rst_addr", F_ADDR, 16'h0000);
    stepCycle();
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b0, 2'd0, 16'h0000, 8'h00, 1'b1, 8'h55);
    checkOutput("run_ready", F_READY, 16'h0001);
    checkOutput("run_pc", F_PC, 16'h0000);
    checkOutput("run_addr", F_ADDR, 16'h0000);
    checkOutput("run_instr_nop", F_INSTR, 16'h00EA);
    stepCycle();
    runCommon(16'h0000, 8'h55);

    // Reset mid-run returns PC and instruction to their startup values
    applyStimulus(1'b1, 1'b1, 2'd0, 16'h0000, 8'h00, 1'b1, 8'h33);
    rst_n = 1'b0;
    checkOutput("midrst_pc", F_PC, 16'h0000);
    checkOutput("midrst_instr", F_INSTR, 16'h00EA);
    checkOutput("midrst_ready", F_READY, 16'h0001);
    stepCycle();
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b1, 2'd0, 16'h0000, 8'h00, 1'b1, 8'h33);
    checkOutput("post_rst_pc", F_PC, 16'h0000);
    stepCycle();
    applyStimulus(1'b1, 1'b0, 2'd0, 16'h0000, 8'h00, 1'b1, 8'h33);
    checkOutput("post_rst_inc", F_PC, 16'h0001);
    stepCycle();
`endif
    stepCycle();
    stepCycle();
    nCompared++;
    if (sbQ.size() != 0) begin
      nMismatched++;
      $display("[TB] FAIL scoreboard_drain: got %0d left expected 0", sbQ.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
